// File: rtl/target_port.sv
// target_port: deserializes bit-serial bus requests into parallel target requests and serializes read data back
module target_port #(
  parameter int ADDR_BITS   = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_in_serial,
  input  logic        bus_in_valid,
  output logic        bus_out_serial,
  output logic        bus_out_valid,
  output logic        bus_ack,
  output logic        bus_err,
  output logic        bus_busy,
  output logic [15:0] target_addr_in,
  output logic        target_addr_in_valid,
  output logic [7:0]  target_data_in,
  output logic        target_data_in_valid,
  output logic        target_rw,
  input  logic [7:0]  target_data_out,
  input  logic        target_data_out_valid,
  input  logic        target_ack,
  input  logic        target_ready
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, ISSUE, WAIT, SEND} state_t;
  state_t                 r_state;
  logic                   r_rw;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [7:0]             r_data;
  logic [7:0]             r_sh;
  logic [4:0]             r_cnt;
  logic [TW-1:0]          r_tmo;
  logic                   w_resp;
  assign w_resp   = r_rw ? target_ack : target_data_out_valid;
  assign bus_busy = (r_state == ISSUE) || (r_state == WAIT) || (r_state == SEND);
  // frame capture, request issue, response wait with timeout, and serial read-data return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state              <= IDLE;
      r_rw                 <= 1'b0;
      r_addr               <= '0;
      r_data               <= '0;
      r_sh                 <= '0;
      r_cnt                <= '0;
      r_tmo                <= '0;
      bus_out_serial       <= 1'b0;
      bus_out_valid        <= 1'b0;
      bus_ack              <= 1'b0;
      bus_err              <= 1'b0;
      target_addr_in       <= '0;
      target_addr_in_valid <= 1'b0;
      target_data_in       <= '0;
      target_data_in_valid <= 1'b0;
      target_rw            <= 1'b0;
    end else begin
      bus_ack              <= 1'b0;
      bus_err              <= 1'b0;
      target_addr_in_valid <= 1'b0;
      target_data_in_valid <= 1'b0;
      case (r_state)
        IDLE: if (bus_in_valid) begin
          r_rw    <= bus_in_serial;
          r_cnt   <= '0;
          r_state <= ADDR;
        end
        ADDR: if (bus_in_valid) begin
          r_addr <= (r_addr >> 1) | (ADDR_BITS'(bus_in_serial) << (ADDR_BITS - 1));
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == 5'(ADDR_BITS - 1)) begin
            r_cnt   <= '0;
            r_state <= r_rw ? DATA : ISSUE;
          end
        end
        DATA: if (bus_in_valid) begin
          r_data <= {bus_in_serial, r_data[7:1]};
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == 5'd7) begin
            r_cnt   <= '0;
            r_state <= ISSUE;
          end
        end
        ISSUE: if (target_ready) begin
          target_addr_in_valid <= 1'b1;
          target_data_in_valid <= r_rw;
          target_addr_in       <= 16'(r_addr);
          target_rw            <= r_rw;
          if (r_rw) target_data_in <= r_data;
          r_tmo   <= TW'(ACK_TIMEOUT);
          r_state <= WAIT;
        end
        WAIT: if (w_resp) begin
          if (r_rw) begin
            bus_ack <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_sh           <= target_data_out;
            bus_out_serial <= target_data_out[0];
            bus_out_valid  <= 1'b1;
            r_cnt          <= '0;
            r_state        <= SEND;
          end
        end else if (r_tmo == '0) begin
          bus_err <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_tmo <= r_tmo - 1'b1;
        end
        SEND: begin
          r_cnt          <= r_cnt + 5'd1;
          r_sh           <= r_sh >> 1;
          bus_out_serial <= r_sh[1];
          bus_ack        <= (r_cnt == 5'd6);
          if (r_cnt == 5'd7) begin
            bus_out_serial <= 1'b0;
            bus_out_valid  <= 1'b0;
            r_cnt          <= '0;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/target_port.md
# target_port

Serial-to-parallel front end for the bus target memory, sitting directly upstream of it. It deserializes a bit-serial request frame (read/write flag, address, optional write data) from the serial bus and issues it as a single parallel request on the target's address/data/rw interface. It then waits for the target's response, returns read data bit-serially, and reports completion or timeout back to the bus.

## Interface
Parameters:
- ADDR_BITS, 16: address bits carried in the frame (1..16); zero-extended to 16 on target_addr_in.
- ACK_TIMEOUT, 15: cycles to wait for a target response before flagging an error (≥1).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset (one clock domain; asserts asynchronously).
- bus_in_serial  in  1  serial request bit.
- bus_in_valid  in  1  bus_in_serial is a valid frame bit this cycle.
- bus_out_serial  out  1  serial read-data bit, LSB first.
- bus_out_valid  out  1  bus_out_serial valid this cycle.
- bus_ack  out  1  one-cycle transaction-complete pulse.
- bus_err  out  1  one-cycle timeout pulse.
- bus_busy  out  1  high in ISSUE/WAIT/SEND; frame bits are dropped while high.
- target_addr_in  out  16  request address to target.
- target_addr_in_valid  out  1  one-cycle request strobe.
- target_data_in  out  8  write data to target.
- target_data_in_valid  out  1  write-data strobe, same cycle as addr strobe on writes.
- target_rw  out  1  1 = write, 0 = read; held stable after issue.
- target_data_out  in  8  read data from target.
- target_data_out_valid  in  1  read data valid.
- target_ack  in  1  target completion pulse.
- target_ready  in  1  target can accept a request.

## Operation
- Frame, one bit per cycle with bus_in_valid high; cycles with bus_in_valid low are gaps and do not advance the frame. Bit order: rw flag, then ADDR_BITS address bits LSB first, then 8 data bits LSB first (writes only).
- States: IDLE, ADDR, DATA, ISSUE, WAIT, SEND.
- IDLE: on a valid bit, latch rw and go to ADDR; clear the bit counter.
- ADDR: shift in address bits. After bit ADDR_BITS-1, go to DATA if rw=1, else ISSUE.
- DATA: shift in 8 bits, then go to ISSUE.
- ISSUE: when target_ready=1, pulse target_addr_in_valid for one cycle. On writes, pulse target_data_in_valid in the same cycle. Load the timeout counter and go to WAIT. If target_ready=0, hold in ISSUE (no timeout applies here).
- WAIT, write: target_ack=1 → bus_ack next cycle, go to IDLE.
- WAIT, read: target_data_out_valid=1 → latch target_data_out into the shift register, go to SEND. target_ack is ignored for reads.
- WAIT, timeout: the counter decrements each cycle. Reaching 0 with no response → bus_err pulse next cycle, go to IDLE. A response in the same cycle as expiry wins over the timeout.
- SEND: drive 8 bits LSB first with bus_out_valid=1, one per cycle. bus_ack pulses coincident with bit 7, then go to IDLE.
- Responses arriving outside WAIT are ignored. bus_in_valid bits arriving in ISSUE/WAIT/SEND are discarded.
- target_addr_in, target_data_in and target_rw are registers; they keep their last values between transactions.

## Timing
- Reset: all outputs 0, state IDLE, counters and shift registers 0. Reset mid-frame or mid-transaction aborts it; no ack/err is produced for it.
- Write, ADDR_BITS=16, back-to-back valid bits, target_ready=1: bits 0..24 arrive on cycles 0..24.
  - Request strobe on cycle 26, where cycle 25 is the register update into ISSUE.
  - Target acks on cycle 27; bus_ack on cycle 28.
- Read: rw plus 16 address bits on cycles 0..16.
  - Strobe on cycle 18; data_out_valid on cycle 19.
  - bus_out bits on cycles 20..27; bus_ack on cycle 27.
- A new frame may start the cycle after returning to IDLE, i.e. the cycle after bus_ack or bus_err.
- bus_ack and bus_err are never high together. Each is a single-cycle pulse.

## Test plan
- Write 0xA5 to address 0x0012, back-to-back bits, ideal target → one strobe with addr 0x0012, data 0xA5, rw=1; bus_ack exactly once; bus_err never.
- Read address 0x0012 after the write → addr strobe with rw=0 and no data strobe; bus_out_serial emits 1,0,1,0,0,1,0,1 over 8 cycles; bus_ack coincident with the last bit.
- Write frame with gaps of 0–3 idle cycles between bits → same request values as the gap-free case.
- Read with target_ready held low 5 cycles → strobe is delayed until ready; no bus_err.
- Read to a non-responding target, ACK_TIMEOUT=15 → bus_err one cycle after expiry (counter reaches 0); no bus_ack; next frame accepted normally.
- rst_n asserted at address bit 8 → outputs 0 immediately; a subsequent full frame completes correctly; frame bits sent while bus_busy=1 → ignored, no second strobe.
